// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: memory-mapped UART transmitter with a TX FIFO and a programmable baud divider.
// Register window at BASE_ADDR: 0x0 TXDATA, 0x4 STATUS, 0x8 DIV.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0100,
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        uart_txd
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

`ifdef UART_PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
`else
    localparam logic PAR_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Register state
    logic [BW-1:0] fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [DW-1:0] div_q;

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          txd_q, txd_d;
`ifdef UART_PARITY_EN
    logic          par_q, par_d;
`endif

    // Bus decode; the byte-offset bits of the address are deliberately ignored
    logic        hit_c;
    logic [1:0]  sel_c;
    logic        wr_tx_c, wr_st_c, wr_div_c;
    logic [31:0] rdata_c;
    logic [31:0] status_c;
    logic        unused_c;

    assign sel_c    = mem_addr[3:2];
    assign hit_c    = (mem_addr[31:4] == BASE_ADDR[31:4]) && (sel_c != 2'd3);
    assign wr_tx_c  = mem_we && hit_c && (sel_c == 2'd0);
    assign wr_st_c  = mem_we && hit_c && (sel_c == 2'd1);
    assign wr_div_c = mem_we && hit_c && (sel_c == 2'd2);
    assign unused_c = ^{mem_addr[1:0], mem_data[31:16]};

    // FIFO flags and handshake; a pop frees a slot for a same-cycle push
    logic full_c, empty_c, busy_c, pop_c, push_c;

    assign full_c  = (count_q == CW'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign pop_c   = (state_q == S_IDLE) && !empty_c;
    assign push_c  = wr_tx_c && (!full_c || pop_c);
    assign busy_c  = (state_q != S_IDLE) || !empty_c;

    // Combinational register readback
    assign status_c = {20'b0, 4'(count_q), 3'b0, PAR_FLAG, ovf_q, empty_c, full_c, busy_c};

    always_comb begin
        rdata_c = '0;
        case (sel_c)
            2'd1:    rdata_c = status_c;
            2'd2:    rdata_c = {16'b0, div_q};
            default: rdata_c = '0;
        endcase
    end

    assign mem_data = (hit_c && !mem_we) ? rdata_c : 32'bz;

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= mem_data[BW-1:0];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and divider register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DW'(CLK_DIV);
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_c) - CW'(pop_c);
            if (wr_tx_c && full_c && !pop_c) begin
                ovf_q <= 1'b1;
            end else if (wr_st_c && mem_data[3]) begin
                ovf_q <= 1'b0;
            end
            if (wr_div_c) begin
                div_q <= (mem_data[DW-1:0] == '0) ? DW'(1) : mem_data[DW-1:0];
            end
        end
    end

    // Serialiser state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Serialiser next state; txd_d is the line level of the state being entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (pop_c) begin
                    state_d = S_START;
                    shift_d = fifo_q[rd_ptr_q];
                    cnt_d   = div_q - DW'(1);
                    txd_d   = 1'b0;
`ifdef UART_PARITY_EN
                    par_d   = ^fifo_q[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = div_q - DW'(1);
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q - DW'(1);
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = par_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_d = S_STOP;
                    cnt_d   = div_q - DW'(1);
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx: register table, directed frame/overflow/reset sequences and randomized traffic
// checked against a frame-timing model of the transmitter.
module tb_uart_tx;

    localparam int unsigned DEPTH   = 8;
    localparam logic [31:0] BASE    = 32'h4000_0100;
    localparam int          TRACE_N = 2048;
`ifdef UART_PARITY_EN
    localparam int          NB = 11;
    localparam logic [31:0] PF = 32'h10;
`else
    localparam int          NB = 10;
    localparam logic [31:0] PF = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_wdata = 32'h0;
    wire  [31:0] mem_data;
    logic        uart_txd;

    assign mem_data = tb_oe ? tb_wdata : 32'bz;

    uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(868), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Line trace, one sample per rising edge
    logic trace [TRACE_N];
    int   trace_base = 0;
    bit   trace_on = 1'b0;
    always @(posedge clk) begin
        #1;
        if (trace_on && cyc >= trace_base && (cyc - trace_base) < TRACE_N)
            trace[cyc - trace_base] <= uart_txd;
    end

    // Model of accepted bytes and the edge at which each was popped
    int         m_pop[$];
    logic [7:0] m_byte[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int e_n);
        @(negedge clk);
        mem_we = 1'b1; mem_addr = a; tb_wdata = d; tb_oe = 1'b1;
        @(posedge clk);
        #1;
        e_n = cyc;
        mem_we = 1'b0; tb_oe = 1'b0; mem_addr = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int e;
        bus_write(a, d, e);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_we = 1'b0; mem_addr = a;
        #1;
        d = mem_data;
        mem_addr = 32'h0;
    endtask

    // Another bus agent drives the data lines; a released bus must carry its value untouched
    task automatic bus_read_foreign(input logic [31:0] a, input logic [31:0] pat, output logic [31:0] d);
        @(negedge clk);
        mem_we = 1'b0; mem_addr = a; tb_wdata = pat; tb_oe = 1'b1;
        #1;
        d = mem_data;
        tb_oe = 1'b0; mem_addr = 32'h0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Line level during slot j of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (NB == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic exp_txd(input int e, input int d);
        foreach (m_pop[i])
            if (e >= m_pop[i] && e < m_pop[i] + NB * d)
                return frame_bit(m_byte[i], (e - m_pop[i]) / d);
        return 1'b1;
    endfunction

    // One frame from idle, checked cycle by cycle
    task automatic send_frame(input logic [7:0] b, input int d);
        int e;
        logic [31:0] st;
        bus_write(BASE, {24'h0, b}, e);
        check("latency_txd_still_idle", 32'(uart_txd), 32'h1);
        bus_read(BASE + 32'h4, st);
        check("status_after_push", st, 32'h101 | PF);
        for (int k = 0; k < NB * d; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("frame_%02h_d%0d_cyc%0d", b, d, k), 32'(uart_txd), 32'(frame_bit(b, k / d)));
        end
        @(posedge clk);
        #1;
        check("idle_after_frame", 32'(uart_txd), 32'h1);
        bus_read(BASE + 32'h4, st);
        check("status_after_frame", st, 32'h4 | PF);
    endtask

    // Random pushes with random gaps against the frame-timing model
    task automatic run_random(input int d, input int n, input int maxgap);
        int e, gap, cnt, p, next_free, end_e, len, mism, first;
        bit popnow, ovf_exp;
        logic [7:0] b;
        logic [31:0] st;
        pulse_reset();
        wr(BASE + 32'h8, 32'(d));
        trace_base = cyc + 1;
        trace_on = 1'b1;
        m_pop.delete();
        m_byte.delete();
        next_free = 0;
        ovf_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(0, maxgap));
            repeat (gap) @(negedge clk);
            b = 8'($urandom);
            bus_write(BASE, {24'h0, b}, e);
            cnt = 0;
            popnow = 1'b0;
            foreach (m_pop[j]) begin
                if (m_pop[j] >= e) cnt++;
                if (m_pop[j] == e) popnow = 1'b1;
            end
            if (cnt < DEPTH || popnow) begin
                p = (e + 1 > next_free) ? e + 1 : next_free;
                m_pop.push_back(p);
                m_byte.push_back(b);
                next_free = p + NB * d + 1;
            end else begin
                ovf_exp = 1'b1;
            end
        end
        end_e = (next_free > cyc) ? next_free : cyc;
        repeat (end_e + 2 - cyc) @(posedge clk);
        #2;
        trace_on = 1'b0;
        len = cyc - trace_base + 1;
        if (len > TRACE_N) len = TRACE_N;
        mism = 0;
        first = -1;
        for (int k = 0; k < len; k++) begin
            if (trace[k] !== exp_txd(trace_base + k, d)) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        check($sformatf("rand_trace_d%0d_n%0d_first_bad_%0d", d, n, first), 32'(mism), 32'h0);
        bus_read(BASE + 32'h4, st);
        check($sformatf("rand_status_d%0d_n%0d", d, n), st, 32'h4 | PF | (ovf_exp ? 32'h8 : 32'h0));
    endtask

    typedef struct packed {
        logic        we;
        logic        foreign;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic i_we, input logic i_fr, input logic [31:0] i_a,
                                input logic [31:0] i_d, input logic [31:0] i_x);
        vec_t v;
        v.we = i_we; v.foreign = i_fr; v.addr = i_a; v.data = i_d; v.exp = i_x;
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        logic [31:0] rd;
        logic [7:0]  ob;

        vecs[0]  = mk(1'b0, 1'b0, 32'h4000_0104, 32'h0, 32'h4 | PF);
        vecs[1]  = mk(1'b0, 1'b0, 32'h4000_0108, 32'h0, 32'd868);
        vecs[2]  = mk(1'b0, 1'b0, 32'h4000_0100, 32'h0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 32'h4000_0108, 32'd5, 32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h4000_0108, 32'h0, 32'd5);
        vecs[5]  = mk(1'b1, 1'b0, 32'h4000_010A, 32'h0, 32'h0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h4000_010B, 32'h0, 32'd1);
        vecs[7]  = mk(1'b1, 1'b0, 32'h4000_0108, 32'hABCD_1234, 32'h0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h4000_0108, 32'h0, 32'h1234);
        vecs[9]  = mk(1'b1, 1'b0, 32'h4000_010C, 32'd7, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, 32'h4000_0118, 32'd9, 32'h0);
        vecs[11] = mk(1'b0, 1'b0, 32'h4000_0108, 32'h0, 32'h1234);
        vecs[12] = mk(1'b0, 1'b1, 32'h4000_010C, $urandom, 32'h0);
        vecs[13] = mk(1'b0, 1'b1, 32'h4000_0110, $urandom, 32'h0);
        vecs[14] = mk(1'b0, 1'b1, 32'h5000_0108, $urandom, 32'h0);
        vecs[15] = mk(1'b0, 1'b1, 32'h4000_0008, $urandom, 32'h0);
        vecs[16] = mk(1'b1, 1'b0, 32'h4000_0104, 32'hFFFF_FFFF, 32'h0);
        vecs[17] = mk(1'b0, 1'b0, 32'h4000_0104, 32'h0, 32'h4 | PF);
        vecs[18] = mk(1'b0, 1'b0, 32'h4000_0107, 32'h0, 32'h4 | PF);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", 32'(uart_txd), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Register map table
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].data);
            end else if (vecs[i].foreign) begin
                bus_read_foreign(vecs[i].addr, vecs[i].data, rd);
                check($sformatf("vec%0d_released_%08h", i, vecs[i].addr), rd, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_read_%08h", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end

        // Directed frames
        wr(BASE + 32'h8, 32'd4);
        send_frame(8'hA5, 4);
        wr(BASE + 32'h8, 32'd0);
        bus_read(BASE + 32'h8, rd);
        check("div_zero_reads_one", rd, 32'd1);
        send_frame(8'h55, 1);
        wr(BASE + 32'h8, 32'd2);
        send_frame(8'h07, 2);

        // Overflow with the default divider, then reset in the middle of a frame
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            ob = (i == 0) ? 8'h00 : 8'(i * 17 + 3);
            wr(BASE, {24'h0, ob});
        end
        bus_read(BASE + 32'h4, rd);
        check("nine_pushes_status", rd, 32'h803 | PF);
        wr(BASE, 32'hEE);
        bus_read(BASE + 32'h4, rd);
        check("overflow_status", rd, 32'h80B | PF);
        wr(BASE + 32'h4, 32'h0);
        bus_read(BASE + 32'h4, rd);
        check("ovf_kept_by_zero_write", rd, 32'h80B | PF);
        wr(BASE + 32'h4, 32'h8);
        bus_read(BASE + 32'h4, rd);
        check("ovf_cleared", rd, 32'h803 | PF);
        repeat (1000) @(posedge clk);
        #1;
        check("mid_data_txd_low", 32'(uart_txd), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_frame_txd", 32'(uart_txd), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(BASE + 32'h4, rd);
        check("reset_mid_frame_status", rd, 32'h4 | PF);
        bus_read(BASE + 32'h8, rd);
        check("reset_mid_frame_div", rd, 32'd868);
        repeat (30) @(posedge clk);
        #1;
        check("fifo_discarded_txd", 32'(uart_txd), 32'h1);
        bus_read(BASE + 32'h4, rd);
        check("fifo_discarded_status", rd, 32'h4 | PF);

        // Randomized traffic
        run_random(1, 20, 0);
        run_random(1, 16, 1);
        run_random(2, 12, 6);
        run_random(3, 10, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
